// File: rtl/branch_predictor_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_predictor_unit
// Purpose  : Dynamic branch predictor for a 5-stage RISC-V pipeline. A
//            direct-mapped BTB plus 2-bit saturating counters predict the
//            next fetch PC. EX-stage resolution trains the tables and raises
//            a registered redirect when the carried prediction was wrong.
// Ports    : clk, rst_n (async, active-low)
//            if_pc -> pred_taken, pred_next_pc        (combinational lookup)
//            ex_valid, ex_is_branch, ex_pc, ex_target,
//            ex_cmp_result, ex_pred_next_pc           (resolution inputs)
//            mispredict, redirect_pc                  (registered redirect)
//            branch_count, mispredict_count           (saturating counters)
// Revision : 1.0 - initial release
// ============================================================================
module branch_predictor_unit #(
  parameter int WIDTH   = 32,
  parameter int ENTRIES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] if_pc,
  output logic             pred_taken,
  output logic [WIDTH-1:0] pred_next_pc,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic [WIDTH-1:0] ex_pc,
  input  logic [WIDTH-1:0] ex_target,
  input  logic             ex_cmp_result,
  input  logic [WIDTH-1:0] ex_pred_next_pc,
  output logic             mispredict,
  output logic [WIDTH-1:0] redirect_pc,
  output logic [31:0]      branch_count,
  output logic [31:0]      mispredict_count
);

  localparam int c_IDX  = $clog2(ENTRIES);
  localparam int c_TAGW = WIDTH - c_IDX - 2;

  // Table storage. Only valid/ctr are reset; tag/target are qualified by valid.
  logic [ENTRIES-1:0] r_valid;
  logic [1:0]         r_ctr    [ENTRIES];
  logic [c_TAGW-1:0]  r_tag    [ENTRIES];
  logic [WIDTH-1:0]   r_target [ENTRIES];

  logic             r_mispredict;
  logic [WIDTH-1:0] r_redirect_pc;
  logic [31:0]      r_branch_count;
  logic [31:0]      r_mispredict_count;

  // ---------------------------------------------------------------- lookup
  logic [c_IDX-1:0]  w_if_idx;
  logic [c_TAGW-1:0] w_if_tag;
  logic              w_if_hit;
  logic [WIDTH-1:0]  w_if_pc_plus4;

  assign w_if_idx      = if_pc[c_IDX+1:2];
  assign w_if_tag      = if_pc[WIDTH-1:c_IDX+2];
  assign w_if_hit      = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
  assign w_if_pc_plus4 = if_pc + WIDTH'(4);

  // Lookup reads the stored state directly: a same-cycle update to the same
  // index is not visible until the following cycle.
  assign pred_taken   = w_if_hit && r_ctr[w_if_idx][1];
  assign pred_next_pc = pred_taken ? r_target[w_if_idx] : w_if_pc_plus4;

  // Byte-offset bits never participate in indexing or tagging.
  logic w_unused_pc_lsbs;
  assign w_unused_pc_lsbs = ^{if_pc[1:0], ex_pc[1:0]};

  // --------------------------------------------------------------- resolve
  logic              w_resolve;
  logic [c_IDX-1:0]  w_ex_idx;
  logic [c_TAGW-1:0] w_ex_tag;
  logic              w_ex_hit;
  logic [WIDTH-1:0]  w_actual_next;
  logic              w_miss_ev;
  logic [1:0]        w_ctr_cur;
  logic [1:0]        w_ctr_next;
  logic [31:0]       w_branch_count_next;
  logic [31:0]       w_mispredict_count_next;

  assign w_resolve     = ex_valid && ex_is_branch;
  assign w_ex_idx      = ex_pc[c_IDX+1:2];
  assign w_ex_tag      = ex_pc[WIDTH-1:c_IDX+2];
  assign w_ex_hit      = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);
  assign w_actual_next = ex_cmp_result ? ex_target : (ex_pc + WIDTH'(4));
  // Comparing full next-PCs catches wrong direction and wrong target alike.
  assign w_miss_ev     = w_resolve && (w_actual_next != ex_pred_next_pc);
  assign w_ctr_cur     = r_ctr[w_ex_idx];

  always_comb begin
    w_ctr_next = w_ctr_cur;
    if (ex_cmp_result) begin
      if (w_ctr_cur != 2'b11) w_ctr_next = w_ctr_cur + 2'b01;
    end else begin
      if (w_ctr_cur != 2'b00) w_ctr_next = w_ctr_cur - 2'b01;
    end
  end

  // Counters are recomputed every edge (hold value when idle or saturated).
  assign w_branch_count_next =
      (w_resolve && (r_branch_count != 32'hFFFF_FFFF)) ? r_branch_count + 32'd1
                                                       : r_branch_count;
  assign w_mispredict_count_next =
      (w_miss_ev && (r_mispredict_count != 32'hFFFF_FFFF)) ? r_mispredict_count + 32'd1
                                                           : r_mispredict_count;

  // ---------------------------------------------------------- table state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_ctr[i] <= 2'b01;
      end
    end else if (w_resolve) begin
      if (w_ex_hit) begin
        r_ctr[w_ex_idx] <= w_ctr_next;
      end else if (ex_cmp_result) begin
        // Taken miss allocates, evicting any aliasing occupant.
        r_valid[w_ex_idx] <= 1'b1;
        r_ctr[w_ex_idx]   <= 2'b10;
      end
    end
  end

  // Tag/target payload: written on any taken resolve (hit refreshes target,
  // miss allocates). Tag is unchanged on a hit, so writing it is harmless.
  always_ff @(posedge clk) begin
    if (w_resolve && ex_cmp_result) begin
      r_tag[w_ex_idx]    <= w_ex_tag;
      r_target[w_ex_idx] <= ex_target;
    end
  end

  // ------------------------------------------------ redirect and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mispredict       <= 1'b0;
      r_redirect_pc      <= '0;
      r_branch_count     <= '0;
      r_mispredict_count <= '0;
    end else begin
      r_mispredict       <= w_miss_ev;
      // redirect_pc only moves with a strobe so it holds between events.
      if (w_miss_ev) r_redirect_pc <= w_actual_next;
      r_branch_count     <= w_branch_count_next;
      r_mispredict_count <= w_mispredict_count_next;
    end
  end

  assign mispredict       = r_mispredict;
  assign redirect_pc      = r_redirect_pc;
  assign branch_count     = r_branch_count;
  assign mispredict_count = r_mispredict_count;

endmodule
`default_nettype wire
